ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller sitting directly upstream of ram_dual.
//  - Owns write/read pointers and drives the RAM's write and read ports.
//  - Exposes valid/ready streaming on both sides.
//  - Hides the RAM's 1-cycle registered read latency behind a 2-entry output skid buffer.
// PARAMETERS
//  WIDTH    16   data word width; must equal the RAM WIDTH
//  DEPTH    32   RAM entries; must be a power of two, = 2**ADDRESS
//  ADDRESS  5    RAM address width
// PORTS
//  i_clk          in   1          clock; all state updates on the rising edge
//  i_rst          in   1          reset, asynchronous, active-high
//  i_flush        in   1          synchronous clear of all contents
//  i_in_valid     in   1          upstream word valid
//  i_in_data      in   WIDTH      upstream word
//  o_in_ready     out  1          controller can accept a word
//  o_out_valid    out  1          head word valid
//  o_out_data     out  WIDTH      head word
//  i_out_ready    in   1          downstream consumes the head word
//  o_ram_cs       out  1          RAM chip select = o_ram_wr_en | o_ram_rd_en
//  o_ram_valid    out  1          RAM i_valid; equals o_ram_wr_en
//  o_ram_wr_en    out  1          RAM write enable
//  o_ram_wr_addr  out  ADDRESS    RAM write address = wr_ptr[ADDRESS-1:0]
//  o_ram_wr_data  out  WIDTH      RAM write data = i_in_data
//  o_ram_rd_en    out  1          RAM read enable
//  o_ram_rd_addr  out  ADDRESS    RAM read address = rd_ptr[ADDRESS-1:0]
//  i_ram_rd_data  in   WIDTH      RAM read data; valid in the cycle after the o_ram_rd_en edge
//  o_count        out  ADDRESS+2  total words held: RAM + in-flight + skid
//  o_full         out  1          RAM region full (wr_ptr - rd_ptr == DEPTH)
//  o_empty        out  1          o_count == 0
// BEHAVIOUR
//  - Reset (async, i_rst=1):
//    - wr_ptr = rd_ptr = 0; skid empty; no read in flight.
//    - Outputs: o_out_valid=0, o_out_data=0, o_count=0, o_empty=1, o_full=0, o_in_ready=0.
//    - All RAM enables are 0 while i_rst is high.
//  - Pointers: wr_ptr and rd_ptr are ADDRESS+1 bits; the MSB is the wrap bit.
//    - RAM count = wr_ptr - rd_ptr, modulo 2**(ADDRESS+1).
//    - Address 31 wraps to 0 with the wrap bit toggled.
//  - Write side:
//    - o_in_ready = !o_full & !i_rst & !i_flush.
//    - push = i_in_valid & o_in_ready. o_ram_wr_en = push, combinational, so the RAM writes on the same edge.
//    - wr_ptr increments on that edge.
//    - When full, i_in_valid is ignored: no RAM write and no data loss. The upstream word holds until ready.
//  - Read side (prefetch):
//    - o_ram_rd_en = (RAM count != 0) & (skid_cnt + inflight - pop < 2) & !i_flush.
//    - pop = o_out_valid & i_out_ready. rd_ptr increments on the rd_en edge.
//    - inflight is set on the rd_en edge. On the next edge i_ram_rd_data is written into the skid and inflight clears, unless a new rd_en re-sets it.
//    - Skid buffer: 2-entry FIFO. o_out_valid = skid_cnt != 0; o_out_data = skid head, registered.
//  - Latency: a word pushed into an empty controller at edge 0 is read at edge 1 and captured at edge 2.
//    - o_out_valid is therefore 1 from edge 2 onward.
//  - Throughput: with i_out_ready held at 1, one word per cycle is sustained after fill.
//  - Read/write collision: the RAM reads only addresses already written (count != 0), so no same-address hazard.
//    - A simultaneous push and RAM read on the same edge is legal.
//  - o_count updates on every edge: +push, -pop; the net change is in {-1, 0, +1}.
//  - i_flush (synchronous, 1 cycle):
//    - Pointers go to 0, skid clears, inflight clears. Data returning from a discarded read is dropped.
//    - push and pop are both suppressed in the flush cycle.
//  - Reset mid-operation: everything returns immediately to reset values. No RAM write completes in the reset cycle.
// STRUCTURE
//  - fifo_pkg holds:
//    - default WIDTH/DEPTH/ADDRESS localparams;
//    - ptr_t, a typedef of logic [ADDRESS:0];
//    - the skid count type.
//  - Sub-module fifo_skid2: the 2-entry output buffer.
//    - Ports: wr/data/rd/count; reset-clears to empty.
//  - Top: pointer logic, read-issue logic, inflight flag, count.
// TESTING
//  1. Reset mid-burst: assert i_rst after 5 pushes -> o_count=0, o_out_valid=0, o_empty=1 within the same cycle.
//  2. Single word: push 0x00A5 with i_out_ready=0 -> o_out_valid=1 at edge 2, o_out_data=0x00A5, o_count=1.
//  3. Fill to 34 words with i_out_ready=0 (32 RAM + 2 skid) -> o_full=1, o_in_ready=0.
//     - The 35th word 0xFFFF is not written. Drain returns 0..33 in order.
//  4. Wrap: write and read 40 words 0x0100+n streaming, with both sides always valid/ready.
//     - Output order is exact; o_ram_wr_addr goes 31 -> 0; 1 word per cycle after the first.
//  5. Backpressure toggle: toggle i_out_ready every other cycle over 20 words -> no drop, no duplicate, o_count never exceeds 34.
//  6. Flush with a read in flight -> o_count=0 next cycle. A subsequent push of 0x1234 is the first word out.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing defaults and types for the RAM-backed FIFO controller.
package fifo_pkg;
  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 32;
  localparam int ADDRESS_DEF = 5;

  // Pointer carries one extra wrap bit above the RAM address.
  typedef logic [ADDRESS_DEF:0] ptr_t;
  typedef logic [1:0]           skid_cnt_t;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output buffer; head entry drives the output directly from a register.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rd_data,
  output skid_cnt_t        o_count
);
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  skid_cnt_t        cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (i_clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case ({i_wr, i_rd})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = i_wr_data;
            cnt_d  = 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_d = i_wr_data;
            cnt_d  = 2'd2;
          end
        end
        2'b01: begin
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            cnt_d  = 2'd1;
          end else if (cnt_q == 2'd1) begin
            cnt_d = 2'd0;
          end
        end
        2'b11: begin
          // Simultaneous write and read keeps occupancy; data shifts toward the head.
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = i_wr_data;
          end else begin
            head_d = i_wr_data;
            cnt_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_rd_data = head_q;
  assign o_count   = cnt_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with 1-cycle registered reads;
// a prefetching read path and 2-entry skid hide the RAM latency.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDRESS = ADDRESS_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_in_valid,
  input  logic [WIDTH-1:0]   i_in_data,
  output logic               o_in_ready,
  output logic               o_out_valid,
  output logic [WIDTH-1:0]   o_out_data,
  input  logic               i_out_ready,
  output logic               o_ram_cs,
  output logic               o_ram_valid,
  output logic               o_ram_wr_en,
  output logic [ADDRESS-1:0] o_ram_wr_addr,
  output logic [WIDTH-1:0]   o_ram_wr_data,
  output logic               o_ram_rd_en,
  output logic [ADDRESS-1:0] o_ram_rd_addr,
  input  logic [WIDTH-1:0]   i_ram_rd_data,
  output logic [ADDRESS+1:0] o_count,
  output logic               o_full,
  output logic               o_empty
);
  localparam ptr_t               PTR_ONE = 1;
  localparam logic [ADDRESS+1:0] CNT_ONE = 1;

  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  logic [ADDRESS+1:0] count_q, count_d;
  logic               inflight_q;

  ptr_t       ram_cnt;
  skid_cnt_t  skid_cnt;
  logic [2:0] occupancy;
  logic       push, pop, rd_en, skid_wr;

  assign ram_cnt    = wr_ptr_q - rd_ptr_q;
  assign o_full     = (ram_cnt == ptr_t'(DEPTH));
  assign o_in_ready = !o_full && !i_rst && !i_flush;
  assign push       = i_in_valid && o_in_ready;
  assign pop        = o_out_valid && i_out_ready && !i_flush;

  // Skid slots already promised after this edge; a new read needs one free.
  assign occupancy = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (ram_cnt != '0) && (occupancy < 3'd2) && !i_flush && !i_rst;
  assign skid_wr   = inflight_q && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
    end
  end

  fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_wr      (skid_wr),
    .i_wr_data (i_ram_rd_data),
    .i_rd      (pop),
    .o_rd_data (o_out_data),
    .o_count   (skid_cnt)
  );

  assign o_out_valid   = (skid_cnt != 2'd0);
  assign o_ram_wr_en   = push;
  assign o_ram_valid   = push;
  assign o_ram_wr_addr = wr_ptr_q[ADDRESS-1:0];
  assign o_ram_wr_data = i_in_data;
  assign o_ram_rd_en   = rd_en;
  assign o_ram_rd_addr = rd_ptr_q[ADDRESS-1:0];
  assign o_ram_cs      = push || rd_en;
  assign o_count       = count_q;
  assign o_empty       = (count_q == '0);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural dual-port RAM attached.
module tb_ram_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        ram_cs, ram_valid, ram_wr_en, ram_rd_en;
  logic [4:0]  ram_wr_addr, ram_rd_addr;
  logic [15:0] ram_wr_data;
  logic [15:0] ram_rd_data = '0;
  logic [6:0]  count;
  logic        full, empty;

  int errors = 0;
  int checks = 0;
  int max_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem [32];

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_ram_cs(ram_cs), .o_ram_valid(ram_valid), .o_ram_wr_en(ram_wr_en),
    .o_ram_wr_addr(ram_wr_addr), .o_ram_wr_data(ram_wr_data),
    .o_ram_rd_en(ram_rd_en), .o_ram_rd_addr(ram_rd_addr), .i_ram_rd_data(ram_rd_data),
    .o_count(count), .o_full(full), .o_empty(empty)
  );

  // Dual-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: reference FIFO is a plain queue; compares on every consumed word
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 1, 0);
          else begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (!(empty && exp_q.size() == 0) && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, 0, 1);
    out_ready = 1'b0;
    cyc();
  endtask

  initial begin
    int sent, got, first, last, wraps, n;
    logic [4:0] prev_addr;

    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ram_cs", 32'(ram_cs), 0);
    rst = 1'b0;
    cyc();

    // Reset mid-burst after 5 pushes
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 16'(16'h0050 + i);
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_wr_en", 32'(ram_wr_en), 0);
    chk("midrst_rd_en", 32'(ram_rd_en), 0);
    in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Single word latency
    in_valid = 1'b1;
    in_data = 16'h00A5;
    cyc();
    in_valid = 1'b0;
    chk("lat_e0_valid", 32'(out_valid), 0);
    cyc();
    chk("lat_e1_valid", 32'(out_valid), 0);
    cyc();
    chk("lat_e2_valid", 32'(out_valid), 1);
    chk("lat_e2_data", 32'(out_data), 32'h00A5);
    chk("lat_e2_count", 32'(count), 1);
    drain("single");

    // Fill to 34 words with the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 34; i++) begin
      in_valid = 1'b1;
      in_data = 16'(i);
      n = 0;
      while (!in_ready && n < 20) begin cyc(); n++; end
      if (n >= 20) chk("fill_stall_timeout", 0, 1);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    chk("fill_full", 32'(full), 1);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), 34);
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("full_no_write", 32'(ram_wr_en), 0);
      cyc();
    end
    chk("full_count_hold", 32'(count), 34);
    drain("fill");

    // Streaming 40 words across the address wrap
    sent = 0; got = 0; first = -1; last = -1; wraps = 0; prev_addr = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 40; c++) begin
      in_valid = (sent < 40);
      in_data = 16'(16'h0100 + sent);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (sent > 0 && prev_addr == 5'd31) begin
          wraps++;
          chk("wrap_addr", 32'(ram_wr_addr), 0);
        end
        prev_addr = ram_wr_addr;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_got", 32'(got), 40);
    chk("stream_wraps", 32'(wraps), 1);
    chk("stream_rate", 32'(last - first), 39);
    drain("stream");

    // Backpressure toggling every other cycle
    max_cnt = 0;
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      out_ready = ((c / 2) % 2 == 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_sent", 32'(sent), 20);
    drain("bp");
    chk("bp_max_count", 32'(max_cnt <= 34), 1);

    // Flush with a read in flight
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_rd_en", 32'(ram_rd_en), 1);
    cyc();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_rd_en", 32'(ram_rd_en), 0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    cyc();
    chk("flush_dropped", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 16'h1234;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin cyc(); n++; end
    chk("flush_first_valid", 32'(out_valid), 1);
    chk("flush_first_data", 32'(out_data), 32'h1234);
    drain("flush");

    // Random soak with occasional flushes
    max_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 60) == 0);
      cyc();
    end
    flush = 1'b0;
    drain("soak");
    chk("soak_max_count", 32'(max_cnt <= 34), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
